// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX
  } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift in the quotient bit.
import mdu_pkg::*;

module mdu_div_step #(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  // Explicit compare keeps a zero divisor well-defined (remainder just accumulates the dividend).
  assign w_ge   = (w_sh >= {1'b0, i_dvs});
  assign w_diff = w_sh[WIDTH-1:0] - i_dvs;
  assign o_rem  = w_ge ? w_diff : w_sh[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO.
// Optional MDU_FAST_MULT_EN: single-cycle multiply, IDLE goes straight to FIX.
import mdu_pkg::*;

module mdu #(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hiw, r_low, r_opb, r_hi, r_lo;
  logic               r_div, r_negq, r_negr, r_dz, r_done;

  logic               w_is_mul, w_is_div, w_sgn, w_go, w_neg_a, w_neg_b, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_drem, w_dquo, w_fix_hi, w_fix_lo;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign w_go     = start && (r_state == S_IDLE) && (w_is_mul || w_is_div);
  assign w_neg_a  = w_sgn && busA[WIDTH-1];
  assign w_neg_b  = w_sgn && busB[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -busA : busA;
  assign w_abs_b  = w_neg_b ? -busB : busB;
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast;
  assign w_fast = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
`ifdef MDU_FAST_MULT_EN
          w_next = w_is_mul ? S_FIX : S_ITER;
`else
          w_next = S_ITER;
`endif
        end
      end
      S_ITER:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply: {r_hiw, r_low} is the product/multiplier shift pair.
  assign w_madd = {1'b0, r_hiw} + (r_low[0] ? {1'b0, r_opb} : '0);

  // Divide: r_hiw is the partial remainder, r_low the dividend/quotient.
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_hiw),
    .i_quo (r_low),
    .i_dvs (r_opb),
    .o_rem (w_drem),
    .o_quo (w_dquo)
  );

  assign w_prod = r_negq ? -{r_hiw, r_low} : {r_hiw, r_low};

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      // Zero divisor leaves |dividend| as remainder, so the sign fix restores busA.
      w_fix_hi = r_negr ? -r_hiw : r_hiw;
      w_fix_lo = r_dz ? WIDTH'(DIV0_LO) : (r_negq ? -r_low : r_low);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt  <= '0;
      r_hiw  <= '0;
      r_low  <= '0;
      r_opb  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_div  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_cnt  <= '0;
            r_div  <= w_is_div;
            r_opb  <= w_abs_b;
            r_dz   <= (busB == '0);
            r_negq <= w_neg_a ^ w_neg_b;
            r_negr <= w_neg_a;
            r_hiw  <= '0;
            r_low  <= w_is_div ? w_abs_a : busB;
            if (w_is_mul) r_opb <= w_abs_a;
            if (w_is_mul) r_low <= w_abs_b;
`ifdef MDU_FAST_MULT_EN
            if (w_is_mul) {r_hiw, r_low} <= w_fast;
`endif
          end else if (start && (op == OP_MTHI)) begin
            r_hi <= busA;
          end else if (start && (op == OP_MTLO)) begin
            r_lo <= busA;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_div) begin
            r_hiw <= w_drem;
            r_low <= w_dquo;
          end else begin
            r_hiw <= w_madd[WIDTH:1];
            r_low <= {w_madd[0], r_low[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
